// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: register-file geometry, ALU function codes
// and the operand-forwarding hit test.
package alu_pkg;

    localparam int unsigned NREGS  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned F_W    = 3;

    localparam logic [F_W-1:0] F_AND = 3'b000;
    localparam logic [F_W-1:0] F_OR  = 3'b001;
    localparam logic [F_W-1:0] F_ADD = 3'b010;
    localparam logic [F_W-1:0] F_SUB = 3'b110;
    localparam logic [F_W-1:0] F_SLT = 3'b111;

    // r0 is constant zero, so an in-flight write to it must never be forwarded
    function automatic logic fwd_hit(input logic             ex_valid,
                                     input logic [IDX_W-1:0] ex_rd,
                                     input logic [IDX_W-1:0] rs);
        return ex_valid && (ex_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/regfile8x32.sv
// 8 x 32 register file: two asynchronous read ports, one synchronous write port,
// entry 0 hardwired to zero.
module regfile8x32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  ra1_i,
    input  logic [IDX_W-1:0]  ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: reads operands (with forwarding from the execute slot), drives an
// external ALU, writes back its result and holds it in a result register for downstream.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [F_W-1:0]    in_f,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [IDX_W-1:0]  in_rs1,
    input  logic [IDX_W-1:0]  in_rs2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [F_W-1:0]    alu_f,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_rd,
    output logic              res_zero
);

    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic              accept, ex_adv;

    logic              ex_valid_q,  ex_valid_d;
    logic [IDX_W-1:0]  ex_rd_q,     ex_rd_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [F_W-1:0]    alu_f_q,     alu_f_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic [IDX_W-1:0]  res_rd_q,    res_rd_d;
    logic              res_zero_q,  res_zero_d;

    regfile8x32 u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (in_rs1),
        .ra2_i (in_rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (ex_adv),
        .wa_i  (ex_rd_q),
        .wd_i  (alu_y)
    );

    assign ex_adv   = ex_valid_q && (!res_valid_q || res_ready);
    assign in_ready = !ex_valid_q || ex_adv;
    assign accept   = in_valid && in_ready;

    // Accepting while ex_valid implies ex_adv, so the forwarded alu_y is also the value
    // being written to the register file on this same edge.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f_d     = alu_f_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;

        if (accept) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = in_rd;
            alu_f_d    = in_f;
            alu_a_d    = fwd_hit(ex_valid_q, ex_rd_q, in_rs1) ? alu_y : rf_rd1;
            alu_b_d    = fwd_hit(ex_valid_q, ex_rd_q, in_rs2) ? alu_y : rf_rd2;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end

        if (ex_adv) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_y;
            res_rd_d    = ex_rd_q;
            res_zero_d  = alu_zero;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; a behavioural ALU closes the loop, code 011 returns
// a bench-chosen constant so registers can be preloaded through ordinary operations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_f, in_rd, in_rs1, in_rs2;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_zero;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic        res_zero;

    logic [31:0] ldval;
    logic [31:0] tb_y;
    int          nchk = 0;
    int          nerr = 0;

    localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010,
                           C_LD  = 3'b011, C_SUB = 3'b110, C_SLT = 3'b111;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_rd    (res_rd),
        .res_zero  (res_zero)
    );

    always_comb begin
        tb_y = '0;
        case (alu_f)
            C_AND:   tb_y = alu_a & alu_b;
            C_OR:    tb_y = alu_a | alu_b;
            C_ADD:   tb_y = alu_a + alu_b;
            C_SUB:   tb_y = alu_a - alu_b;
            C_SLT:   tb_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            C_LD:    tb_y = ldval;
            default: tb_y = alu_a ^ alu_b;
        endcase
    end
    assign alu_y    = tb_y;
    assign alu_zero = (tb_y == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        in_valid = 1'b1;
        in_f     = f;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    // Issue one op with an empty pipe; returns with its result visible in the result register.
    task automatic op(input logic [2:0] f, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2);
        int unsigned waited;
        waited = 0;
        drive(f, rd, rs1, rs2);
        while (!in_ready && waited < 10) begin
            step();
            waited++;
        end
        chk("op_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("op_res_valid", {31'b0, res_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_f      = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        res_ready = 1'b1;
        ldval     = '0;
        step();
        step();
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data",  res_data, 32'd0);
        chk("rst_res_rd",    {29'b0, res_rd}, 32'd0);
        chk("rst_res_zero",  {31'b0, res_zero}, 32'd0);
        chk("rst_alu_a",     alu_a, 32'd0);
        chk("rst_alu_f",     {29'b0, alu_f}, 32'd0);
        rst_n = 1'b1;
        chk("rel_in_ready",  {31'b0, in_ready}, 32'd1);

        // ADD r1 = r0 + r0, latency one edge after accept
        drive(C_ADD, 3'd1, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        chk("add0_not_yet", {31'b0, res_valid}, 32'd0);
        step();
        chk("add0_valid", {31'b0, res_valid}, 32'd1);
        chk("add0_data",  res_data, 32'd0);
        chk("add0_zero",  {31'b0, res_zero}, 32'd1);
        chk("add0_rd",    {29'b0, res_rd}, 32'd1);
        step();
        chk("add0_drained", {31'b0, res_valid}, 32'd0);

        // Preload r2=5, r3=3, then SUB and SLT
        ldval = 32'd5;
        op(C_LD, 3'd2, 3'd0, 3'd0);
        chk("ld_r2", res_data, 32'd5);
        step();
        ldval = 32'd3;
        op(C_LD, 3'd3, 3'd0, 3'd0);
        chk("ld_r3", res_data, 32'd3);
        step();
        op(C_SUB, 3'd4, 3'd2, 3'd3);
        chk("sub_data", res_data, 32'd2);
        chk("sub_zero", {31'b0, res_zero}, 32'd0);
        chk("sub_rd",   {29'b0, res_rd}, 32'd4);
        step();
        op(C_SLT, 3'd5, 3'd3, 3'd2);
        chk("slt_data", res_data, 32'd1);
        step();

        // Back-to-back with forwarding: r1 = r2+r3 = 8, r6 = r1+r1 = 16
        drive(C_ADD, 3'd1, 3'd2, 3'd3);
        step();
        drive(C_ADD, 3'd6, 3'd1, 3'd1);
        chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_first",  res_data, 32'd8);
        chk("b2b_fwd_a",  alu_a, 32'd8);
        chk("b2b_fwd_b",  alu_b, 32'd8);
        step();
        chk("b2b_valid",  {31'b0, res_valid}, 32'd1);
        chk("b2b_second", res_data, 32'd16);
        chk("b2b_rd",     {29'b0, res_rd}, 32'd6);
        step();

        // Stall: A = OR r7=r2|r3 (7), B = ADD r4=r6+r2 (21), C = SUB r1=r2-r3 (2) held off
        res_ready = 1'b0;
        drive(C_OR, 3'd7, 3'd2, 3'd3);
        step();
        drive(C_ADD, 3'd4, 3'd6, 3'd2);
        chk("stall_b_ready", {31'b0, in_ready}, 32'd1);
        step();
        drive(C_SUB, 3'd1, 3'd2, 3'd3);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_data0",    res_data, 32'd7);
        step();
        chk("stall_data1",    res_data, 32'd7);
        chk("stall_rd1",      {29'b0, res_rd}, 32'd7);
        chk("stall_alu_a",    alu_a, 32'd16);
        chk("stall_alu_f",    {29'b0, alu_f}, {29'b0, C_ADD});
        step();
        chk("stall_data2",    res_data, 32'd7);
        chk("stall_ready2",   {31'b0, in_ready}, 32'd0);
        res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rel_b_data",  res_data, 32'd21);
        chk("rel_b_rd",    {29'b0, res_rd}, 32'd4);
        chk("rel_c_alu_f", {29'b0, alu_f}, {29'b0, C_SUB});
        step();
        chk("rel_c_data",  res_data, 32'd2);
        chk("rel_c_rd",    {29'b0, res_rd}, 32'd1);
        step();
        chk("rel_drained", {31'b0, res_valid}, 32'd0);

        // Write to r0 followed immediately by a read of r0: no forwarding, no write
        ldval = 32'hDEADBEEF;
        drive(C_LD, 3'd0, 3'd0, 3'd0);
        step();
        drive(C_ADD, 3'd1, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        chk("r0_wr_data", res_data, 32'hDEADBEEF);
        chk("r0_alu_a",   alu_a, 32'd0);
        chk("r0_alu_b",   alu_b, 32'd0);
        step();
        chk("r0_read",    res_data, 32'd0);
        step();

        // Reset with an op in flight: r5 would become 0x55 but must stay 0
        ldval = 32'h55;
        drive(C_LD, 3'd5, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {31'b0, res_valid}, 32'd0);
        op(C_ADD, 3'd1, 3'd5, 3'd2);
        chk("post_rst_r5", alu_a, 32'd0);
        chk("post_rst_r2", alu_b, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL expose its ports exactly as listed; one clock, reset asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  stage accepts request this cycle.
REQ-006 in_f  input  3  ALU function code.
REQ-007 in_rd / in_rs1 / in_rs2  input  3 each  destination and source register indices.
REQ-008 alu_a / alu_b  output  32 each  registered operands driven to the ALU.
REQ-009 alu_f  output  3  registered function code driven to the ALU.
REQ-010 alu_y  input  32  combinational ALU result for current alu_a/alu_b/alu_f.
REQ-011 alu_zero  input  1  ALU zero flag.
REQ-012 res_valid  output  1  result register holds an unconsumed result.
REQ-013 res_ready  input  1  downstream consumes result.
REQ-014 res_data / res_rd / res_zero  output  32 / 3 / 1  captured result, its destination, its zero flag.

Function
REQ-015 The block SHALL hold an 8 x 32 register file; index 0 SHALL read as 0 and ignore writes.
REQ-016 Accept = in_valid && in_ready; on accept, rs1/rs2 values SHALL be registered into alu_a/alu_b, in_f into alu_f, in_rd into ex_rd, and ex_valid set.
REQ-017 ex_adv = ex_valid && (!res_valid || res_ready); in_ready SHALL equal !ex_valid || ex_adv (combinational).
REQ-018 On ex_adv the block SHALL write alu_y to regfile[ex_rd] and load res_data=alu_y, res_zero=alu_zero, res_rd=ex_rd, res_valid=1.
REQ-019 ex_valid SHALL clear on ex_adv without simultaneous accept; remains set on simultaneous accept.
REQ-020 res_valid SHALL clear when res_ready && res_valid && !ex_adv.
REQ-021 While res_valid && !res_ready, res_data/res_rd/res_zero and alu_a/alu_b/alu_f SHALL hold stable.
REQ-022 Forwarding: on accept, if ex_valid && ex_rd==rsN && rsN!=0, operand N SHALL take alu_y instead of the register file.
REQ-023 Latency: accept at edge k -> res_valid at edge k+1 when unstalled; throughput one op/cycle.
REQ-024 Codes 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes SHALL be passed through unmodified and their result written as produced by the ALU.
REQ-025 in_valid without in_ready SHALL cause no state change; requester holds request.

Reset
REQ-026 While rst_n low: all register-file entries, alu_a, alu_b, alu_f, ex_rd, res_data, res_rd, res_zero = 0; ex_valid, res_valid = 0.
REQ-027 in_ready SHALL be 1 immediately after reset deassertion.
REQ-028 Reset mid-operation SHALL discard in-flight ops with no register-file write.

Structure
REQ-029 ALU function-code constants, register count, and index width SHALL live in a shared package alu_pkg.
REQ-030 The register file SHALL be sub-module regfile8x32 (2 async read ports, 1 sync write port, r0 hardwired zero).

Verification
REQ-031 Reset then op ADD r1=r0+r0 -> res_valid next cycle, res_data=0, res_zero=1, res_rd=1.
REQ-032 Preload r2=5, r3=3 (via ops), SUB rd=4 rs1=2 rs2=3 -> res_data=2, res_zero=0; SLT rd=5 rs1=3 rs2=2 -> res_data=1.
REQ-033 Back-to-back ADD r1=r2+r3 (8) then ADD r6=r1+r1 -> forwarding yields res_data=16.
REQ-034 res_ready held low 3 cycles with two ops issued -> in_ready=0 after second accept, res_data stable, no op lost or duplicated on release.
REQ-035 Write targeting r0 with alu_y=0xDEADBEEF -> later read of r0 yields alu_a=0.
REQ-036 Assert rst_n low with ex_valid=1 -> res_valid=0, target register unchanged (reads 0).
